// File: rtl/line_checker.sv
// Line checker: pulls bytes from a show-ahead source, splits them into
// LF-terminated lines and flags each non-blank line as "Hello" or not.
module line_checker #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             empty,
  output logic             get,
  output logic             line_ok,
  output logic             line_bad,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count,
  output logic             led
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_REF = LW'(5);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EVAL
  } state_t;

  state_t           state_q, state_d;
  logic             get_q, get_d;
  logic [7:0]       byte_q, byte_d;
  logic [LW-1:0]    len_q, len_d;
  logic             miss_q, miss_d;
  logic             ovf_q, ovf_d;
  logic             ok_q, ok_d;
  logic             bad_q, bad_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] badc_q, badc_d;
  logic             led_q, led_d;

  function automatic logic [7:0] ref_byte(input logic [LW-1:0] idx);
    logic [7:0] b;
    case (idx)
      LW'(0):  b = 8'h48;
      LW'(1):  b = 8'h65;
      LW'(2):  b = 8'h6C;
      LW'(3):  b = 8'h6C;
      default: b = 8'h6F;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    get_d   = 1'b0;
    byte_d  = byte_q;
    len_d   = len_q;
    miss_d  = miss_q;
    ovf_d   = ovf_q;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    good_d  = good_q;
    badc_d  = badc_q;
    led_d   = led_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = FETCH;
          get_d   = 1'b1;
        end
      end
      FETCH: begin
        byte_d  = in;
        state_d = EVAL;
      end
      EVAL: begin
        state_d = IDLE;
        if (byte_q == 8'h0D) begin
          // CR is transparent so CRLF and LF lines compare alike
        end else if (byte_q == 8'h0A) begin
          if (len_q != '0) begin
            if (len_q == LEN_REF && !miss_q && !ovf_q) begin
              ok_d   = 1'b1;
              good_d = good_q + 1'b1;
              led_d  = ~led_q;
            end else begin
              bad_d  = 1'b1;
              badc_d = badc_q + 1'b1;
            end
            len_d  = '0;
            miss_d = 1'b0;
            ovf_d  = 1'b0;
          end
        end else begin
          if (len_q < LEN_REF) begin
            if (byte_q != ref_byte(len_q)) miss_d = 1'b1;
          end else begin
            miss_d = 1'b1;
          end
          if (len_q == LEN_MAX) ovf_d = 1'b1;
          else len_d = len_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      get_q   <= 1'b0;
      byte_q  <= '0;
      len_q   <= '0;
      miss_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
      good_q  <= '0;
      badc_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      get_q   <= get_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      miss_q  <= miss_d;
      ovf_q   <= ovf_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      good_q  <= good_d;
      badc_q  <= badc_d;
      led_q   <= led_d;
    end
  end

  assign get        = get_q;
  assign line_ok    = ok_q;
  assign line_bad   = bad_q;
  assign good_count = good_q;
  assign bad_count  = badc_q;
  assign led        = led_q;

endmodule

// File: doc/line_checker.md
# line_checker

Byte sink for the receive direction of the UART test path. It pulls bytes from a show-ahead byte source with an `empty`/`get` interface, such as the RX FIFO output. It assembles them into lines terminated by LF, compares each line against the fixed greeting "Hello" and reports the verdict for every line. It sits after `uart_rx_fifo` in the loopback bench, is clocked by `uart_clock_16`, and drives the board LED as a pass indicator.

## Interface

Parameters:
- `MAX_LEN`, 16: line length limit in bytes (excluding CR/LF); length counter saturates here.
- `CNT_W`, 8: width of the good/bad line counters.

Ports:
- `clock`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-high reset.
- `in`, in, 8: byte from source; valid whenever `empty` is low (show-ahead).
- `empty`, in, 1: source has no byte.
- `get`, out, 1: one-cycle pop strobe to source.
- `line_ok`, out, 1: one-cycle pulse, line matched "Hello".
- `line_bad`, out, 1: one-cycle pulse, non-empty line did not match.
- `good_count`, out, CNT_W: matched lines, wraps modulo 2^CNT_W.
- `bad_count`, out, CNT_W: mismatched lines, wraps modulo 2^CNT_W.
- `led`, out, 1: toggles on every matched line.

## Operation

- Expected text is internal constant "Hello" = 48 65 6C 6C 6F, with length 5.
- Line state registers:
  - `len`: log2(MAX_LEN+1) bits, saturating at MAX_LEN.
  - `miss`: sticky mismatch flag.
  - `ovf`: sticky, set when a byte arrives with `len` == MAX_LEN.
- FSM states: IDLE, FETCH, EVAL.
  - IDLE: `get`=0. If `empty`=0, go to FETCH. Otherwise stay in IDLE.
  - FETCH: `get`=1 for exactly this cycle. Latch `in` into `byte_r`. Go to EVAL.
  - EVAL: `get`=0. Classify `byte_r`, then go to IDLE.
- Classification in EVAL:
  - 0x0D (CR): ignored; no state change.
  - 0x0A (LF) with `len`=0: blank line; ignored, no pulse.
  - 0x0A with `len`>0:
    - ok = (`len`==5) & !`miss` & !`ovf`.
    - If ok: pulse `line_ok`, increment `good_count`, toggle `led`.
    - Else: pulse `line_bad`, increment `bad_count`.
    - Clear `len`, `miss` and `ovf`.
  - Any other byte:
    - If `len`<5 and byte != expected[`len`], set `miss`.
    - If `len`>=5, set `miss`.
    - If `len`==MAX_LEN, set `ovf`. Otherwise increment `len`.
- NUL (0x00) is an ordinary byte.
- `line_ok` and `line_bad` are never high together.

## Timing

- Reset values:
  - Outputs: `get`, `line_ok`, `line_bad`, `led` = 0; both counters = 0.
  - Internal: FSM in IDLE; `len`=0, `miss`=0, `ovf`=0, `byte_r`=0.
- Reset is sampled on the clock edge. Reset asserted in any state, including mid-line or in FETCH, discards the partial line and gives the reset values on the next cycle. A pop already strobed is not replayed.
- Handshake:
  - `get` is registered and is high one cycle per byte.
  - `in` is sampled at the end of the cycle in which `get`=1.
  - The source must update `empty`/`in` within one cycle of `get` falling; the mandatory IDLE cycle provides that gap.
- Throughput: one byte per 3 clocks when the source stays non-empty.
- Latency: a `line_ok`/`line_bad` pulse is high for one cycle. That cycle is the one after the EVAL cycle of the terminating LF, i.e. 3 clocks after the IDLE cycle that saw the LF present.
  - Counters and `led` update in the same cycle as the pulse.
- `empty` rising during FETCH is a source protocol violation. The block still latches `in`; there is no defined recovery.
- Counter wrap: `good_count` at 2^CNT_W−1 plus one matched line = 0. No overflow flag.

## Test plan

- Reset:
  - Hold `reset` 3 cycles with `empty`=0 → `get` stays 0 throughout.
  - All outputs are 0 one cycle after `reset` falls.
  - First `get` pulse comes 2 cycles after release.
- Good line:
  - Feed 48 65 6C 6C 6F 0D 0A from a show-ahead model → exactly 7 `get` pulses, spaced 3 cycles apart.
  - One `line_ok` pulse; `good_count`=1; `led`=1; `bad_count`=0.
- Mismatch variants:
  - "Hellp\n" → `line_bad`, `bad_count`=1.
  - "Hell\n" → `line_bad`, `bad_count`=2.
  - "Hello!\n" → `line_bad`, `bad_count`=3.
  - `good_count` unchanged after all three.
- Blank lines and overflow:
  - "\r\n\n" → no pulses, counters unchanged.
  - 20 × 0x41 then LF with MAX_LEN=16 → single `line_bad`; next "Hello\n" → `line_ok`, since flags were cleared.
- Starvation and reset mid-line:
  - Feed "Hel", hold `empty`=1 for 50 cycles → `get` stays 0.
  - Assert `reset` 1 cycle, then feed "lo\n" → `line_bad`, since the partial line was discarded.
- Counter wrap with CNT_W=2:
  - Send "Hello\n" 5 times → `good_count` sequence is 1,2,3,0,1.
  - `led` ends at 1.
